// File: rtl/wwm_projectile.sv
// wwm_projectile: launches a projectile from a fixed point and advances it
// once per physics tick under constant horizontal speed and stepped gravity,
// then reports whether it landed in the target window (Hit) or left the
// playfield or timed out (Miss).
//
// state  | meaning
// IDLE   | waiting for Launch; position and t_air frozen
// FLIGHT | physics ticks advance position; result checked every cycle
module wwm_projectile #(
  parameter int X_INITIAL = 200,
  parameter int Y_INITIAL = 400,
  parameter int TICK_DIV  = 1666667,
  parameter int GRAV_DIV  = 4
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Launch,
  input  logic       Abort,
  input  logic [3:0] vX,
  input  logic [3:0] vY,
  output logic [9:0] projectileCenterX,
  output logic [9:0] projectileCenterY,
  output logic [9:0] t_air,
  output logic       Busy,
  output logic       Hit,
  output logic       Miss
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GRAV_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(GRAV_DIV - 1);
  localparam logic [9:0]        X_INIT    = 10'(X_INITIAL);
  localparam logic [9:0]        Y_INIT    = 10'(Y_INITIAL);
  localparam logic [7:0]        VY_MIN    = 8'h80;

  // Target window and playfield limits, in pixels.
  localparam logic [9:0] HIT_X_LO  = 10'd650;
  localparam logic [9:0] HIT_X_HI  = 10'd675;
  localparam logic [9:0] HIT_Y_LO  = 10'd470;
  localparam logic [9:0] HIT_Y_HI  = 10'd475;
  localparam logic [9:0] MISS_X_HI = 10'd775;
  localparam logic [9:0] MISS_X_LO = 10'd160;
  localparam logic [9:0] MISS_Y_HI = 10'd475;
  localparam logic [9:0] MISS_Y_LO = 10'd50;
  localparam logic [9:0] T_LAST    = 10'd1023;

  typedef enum logic {
    IDLE   = 1'b0,
    FLIGHT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  tick_cnt;
  logic [GRAV_W-1:0] grav_cnt;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [3:0]        vx;
  logic signed [7:0] vy;

  logic tick;
  logic hit_det;
  logic miss_det;
  logic launch_go;
  logic tick_go;
  logic hit_nxt;
  logic miss_nxt;

  logic signed [10:0] y_diff;
  logic [9:0]         y_new;

  assign tick = (state == FLIGHT) && (tick_cnt == CNT_LAST);

  assign hit_det = (pos_x >= HIT_X_LO) && (pos_x <= HIT_X_HI) &&
                   (pos_y >= HIT_Y_LO) && (pos_y <= HIT_Y_HI);

  assign miss_det = (pos_x >= MISS_X_HI) || (pos_x <= MISS_X_LO) ||
                    (pos_y >= MISS_Y_HI) || (pos_y <= MISS_Y_LO) ||
                    (t_air == T_LAST);

  // Upward speed raises the projectile, so it is subtracted; anything that
  // would go above the top edge is pinned at row 0.
  assign y_diff = $signed({1'b0, pos_y}) - $signed({{3{vy[7]}}, vy});
  assign y_new  = y_diff[10] ? 10'd0 : y_diff[9:0];

  // State register and registered result pulses.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      Hit   <= 1'b0;
      Miss  <= 1'b0;
    end else begin
      state <= state_nxt;
      Hit   <= hit_nxt;
      Miss  <= miss_nxt;
    end
  end

  // Next state, launch/tick qualification and result decode.
  // Abort beats a pending result; a result beats a coincident tick so the
  // reported position is the one that triggered it.
  always_comb begin
    state_nxt = state;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    launch_go = 1'b0;
    tick_go   = 1'b0;
    case (state)
      IDLE: begin
        if (Launch && !Abort) begin
          state_nxt = FLIGHT;
          launch_go = 1'b1;
        end
      end
      FLIGHT: begin
        if (Abort) begin
          state_nxt = IDLE;
        end else if (hit_det) begin
          state_nxt = IDLE;
          hit_nxt   = 1'b1;
        end else if (miss_det) begin
          state_nxt = IDLE;
          miss_nxt  = 1'b1;
        end else begin
          tick_go = tick;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Physics tick divider; runs only while in flight.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tick_cnt <= '0;
    end else if (launch_go) begin
      tick_cnt <= '0;
    end else if (state == FLIGHT) begin
      tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // Position, flight time and velocity. grav_cnt tracks t_air modulo
  // GRAV_DIV, so it reaching GRAV_LAST means the new t_air is a multiple.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pos_x    <= X_INIT;
      pos_y    <= Y_INIT;
      t_air    <= 10'd0;
      vx       <= 4'd0;
      vy       <= 8'sd0;
      grav_cnt <= '0;
    end else if (launch_go) begin
      pos_x    <= X_INIT;
      pos_y    <= Y_INIT;
      t_air    <= 10'd0;
      vx       <= vX;
      vy       <= $signed({4'b0000, vY});
      grav_cnt <= '0;
    end else if (tick_go) begin
      pos_x    <= pos_x + {6'b000000, vx};
      pos_y    <= y_new;
      t_air    <= t_air + 10'd1;
      grav_cnt <= (grav_cnt == GRAV_LAST) ? '0 : grav_cnt + GRAV_W'(1);
      if ((grav_cnt == GRAV_LAST) && (vy != VY_MIN)) begin
        vy <= vy - 8'sd1;
      end
    end
  end

  assign projectileCenterX = pos_x;
  assign projectileCenterY = pos_y;
  assign Busy              = (state == FLIGHT);

endmodule

// File: doc/wwm_projectile.md
WWM_PROJECTILE -- requirements
Module: wwm_projectile

Interface
REQ-001 The block SHALL have parameter X_INITIAL, default 200, meaning launch X position in pixels.
REQ-002 The block SHALL have parameter Y_INITIAL, default 400, meaning launch Y position in pixels; Y grows downward.
REQ-003 The block SHALL have parameter TICK_DIV, default 1666667, meaning clk cycles per physics tick (60 Hz at 100 MHz).
REQ-004 The block SHALL have parameter GRAV_DIV, default 4, meaning physics ticks per 1-unit gravity decrement of vertical velocity.
REQ-005 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit; reset is asynchronous and active-high.
REQ-007 The block SHALL have port Launch, input, 1 bit, a start-flight request sampled only in IDLE.
REQ-008 The block SHALL have port Abort, input, 1 bit, a synchronous return to IDLE.
REQ-009 The block SHALL have ports vX and vY, input, 4 bits each, unsigned launch speeds sampled on the accepted Launch cycle.
REQ-010 The block SHALL have ports projectileCenterX and projectileCenterY, output, 10 bits each, the current position.
REQ-011 The block SHALL have port t_air, output, 10 bits, the physics ticks elapsed in the current flight.
REQ-012 The block SHALL have ports Busy, Hit and Miss, output, 1 bit each: Busy is high in FLIGHT; Hit and Miss are single-cycle result pulses.

Function
REQ-013 The state machine SHALL have exactly two states: IDLE and FLIGHT.
REQ-014 In IDLE, when Launch=1 and Abort=0, the block SHALL on the next edge:
- enter FLIGHT
- load X=X_INITIAL, Y=Y_INITIAL and t_air=0
- latch vx={vX} and signed 8-bit vy={4'b0,vY}
- clear the tick counter.
REQ-015 Launch SHALL be ignored while in FLIGHT.
REQ-016 The tick counter SHALL count 0..TICK_DIV-1 in FLIGHT only and assert an internal tick on the cycle the count equals TICK_DIV-1, then wrap to 0.
REQ-017 On each tick, position and time SHALL update as X<=X+vx, Y<=Y-vy (using vy before its update) and t_air<=t_air+1.
REQ-018 On a tick where the new t_air is a multiple of GRAV_DIV, vy SHALL decrement by 1, saturating at -128.
REQ-019 Y arithmetic SHALL use 11-bit signed intermediates; a result below 0 SHALL clamp to 0.
REQ-020 Every FLIGHT cycle SHALL check the registered position; the Hit check SHALL take priority over the Miss check.
REQ-021 Hit SHALL be detected when 650<=X<=675 and 470<=Y<=475.
REQ-022 Miss SHALL be detected when X>=775, X<=160, Y>=475, Y<=50, or t_air=1023.
REQ-023 On detection, the block SHALL pulse Hit or Miss high for exactly one cycle, return to IDLE, and freeze position and t_air.
REQ-024 An Abort in FLIGHT SHALL return the block to IDLE on the next edge with no Hit/Miss pulse and position held; Abort in IDLE SHALL have no effect.
REQ-025 Launch and Abort asserted together in IDLE SHALL be treated as no launch.
REQ-026 Hit and Miss SHALL never be asserted in the same cycle.
REQ-027 Position, t_air and vy SHALL change only on a tick or on the accepted Launch cycle.

Reset
REQ-028 On Reset=1, regardless of clk and mid-flight, the block SHALL force IDLE and set:
- projectileCenterX=X_INITIAL and projectileCenterY=Y_INITIAL
- t_air=0, vy=0 and tick counter=0
- Busy=0, Hit=0 and Miss=0.
REQ-029 After Reset is released, the first Launch SHALL be accepted on the first rising edge at which it is sampled high.

Verification (TICK_DIV=4, GRAV_DIV=4)
REQ-030 The bench SHALL drive Reset mid-flight and check that all outputs return to their reset values immediately, before the next clk edge.
REQ-031 The bench SHALL launch with vX=15, vY=0 and check:
- Y=400 for ticks 1-4
- Y=404 at tick 8
- Miss pulse when t_air=27, X=605, Y=478.
REQ-032 The bench SHALL launch with vX=15, vY=1 and check:
- Y=468 at tick 30
- Hit pulse when t_air=31, X=665, Y=474
- no Miss pulse in that flight.
REQ-033 The bench SHALL launch with vX=0, vY=15 and check:
- Y decreases until Y<=50
- Miss pulses once
- Busy falls on the same cycle the pulse is seen.
REQ-034 The bench SHALL pulse Launch during FLIGHT and check no reload occurs.
REQ-035 The bench SHALL assert Abort at tick 5 and check:
- IDLE on the next edge
- X and Y held
- no Hit or Miss pulse
- a subsequent Launch restarts from (200,400) with t_air=0.
